// File: rtl/sdram_pkg.sv
// sdram_pkg: shared types and constants for the SDRAM request queue.
//   rq_state_e       - request sequencer states
//   req_entry_t      - one buffered host request {write, addr, wdata}
//   RSP_TIMEOUT_DATA - read data returned when a read is abandoned by the watchdog
// SDRAM_ADDR_W is the address width the entry struct carries; the queue's
// ADDR_WIDTH parameter should not exceed it.
package sdram_pkg;

  localparam int unsigned SDRAM_ADDR_W = 25;

  localparam logic [7:0] RSP_TIMEOUT_DATA = 8'hFF;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_ISSUE   = 2'd1,
    S_WAIT_RD = 2'd2
  } rq_state_e;

  typedef struct packed {
    logic                    write;
    logic [SDRAM_ADDR_W-1:0] addr;
    logic [7:0]              wdata;
  } req_entry_t;

  localparam int unsigned REQ_ENTRY_W = $bits(req_entry_t);

endpackage

// File: rtl/sdram_req_fifo.sv
// sdram_req_fifo: synchronous FIFO with occupancy count.
//   sd_clk, rst_n     - clock, synchronous active-low reset (empties the FIFO)
//   push, wdata       - write one entry (ignored when full)
//   pop               - drop the head entry (ignored when empty)
//   rdata             - current head entry (valid when !empty)
//   level, full, empty- occupancy status
// Pointers carry one extra MSB so full and empty are distinguishable after wrap.
module sdram_req_fifo #(
  parameter int unsigned DEPTH = 8,
  parameter int unsigned WIDTH = 34,
  localparam int unsigned AW   = $clog2(DEPTH)
) (
  input  logic             sd_clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic [AW:0]      level,
  output logic             full,
  output logic             empty
);

  localparam logic [AW:0] PTR_INC  = {{AW{1'b0}}, 1'b1};
  localparam logic [AW:0] LVL_FULL = {1'b1, {AW{1'b0}}};

  logic [WIDTH-1:0] mem_r [DEPTH];
  logic [AW:0]      wr_ptr_r;
  logic [AW:0]      rd_ptr_r;
  logic             push_ok_s;
  logic             pop_ok_s;

  assign level     = wr_ptr_r - rd_ptr_r;
  assign full      = (level == LVL_FULL);
  assign empty     = (wr_ptr_r == rd_ptr_r);
  assign push_ok_s = push && !full;
  assign pop_ok_s  = pop && !empty;
  assign rdata     = mem_r[rd_ptr_r[AW-1:0]];

  // Entry storage; contents need no reset because the pointers gate visibility.
  always_ff @(posedge sd_clk) begin
    if (push_ok_s) begin
      mem_r[wr_ptr_r[AW-1:0]] <= wdata;
    end
  end

  // Read/write pointers.
  always_ff @(posedge sd_clk) begin
    if (!rst_n) begin
      wr_ptr_r <= {(AW+1){1'b0}};
      rd_ptr_r <= {(AW+1){1'b0}};
    end else begin
      if (push_ok_s) begin
        wr_ptr_r <= wr_ptr_r + PTR_INC;
      end
      if (pop_ok_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_INC;
      end
    end
  end

endmodule

// File: rtl/sdram_request_queue.sv
// sdram_request_queue: host-side request buffer in front of an SDRAM controller.
//   Host side : req_valid/req_ready/req_write/req_addr/req_wdata (push into FIFO),
//               rsp_valid/rsp_ready/rsp_rdata (single-entry read response)
//   Ctl side  : ctl_wr_enable/ctl_wr_addr/ctl_wr_data, ctl_rd_enable/ctl_rd_addr,
//               ctl_ack, ctl_rd_ready/ctl_rd_data
//   Status    : level (FIFO occupancy), error (sticky watchdog flag)
//   Clock sd_clk, reset rst_n (synchronous, active-low).
// Requests complete in order; at most one read is outstanding and a read is
// not issued while a response is still held. Writes may issue past a held
// response.
// Optional build macro SDRAM_RQ_WDOG_EN adds a watchdog on S_ISSUE/S_WAIT_RD
// that abandons the request after WDOG_CYCLES cycles, sets error and, for a
// read, returns RSP_TIMEOUT_DATA. Without it the sequencer waits indefinitely
// and error is tied low.
module sdram_request_queue
  import sdram_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH  = 25,
  parameter int unsigned DEPTH       = 8,
  parameter int unsigned WDOG_CYCLES = 64
) (
  input  logic                    sd_clk,
  input  logic                    rst_n,
  input  logic                    req_valid,
  output logic                    req_ready,
  input  logic                    req_write,
  input  logic [ADDR_WIDTH-1:0]   req_addr,
  input  logic [7:0]              req_wdata,
  output logic                    rsp_valid,
  input  logic                    rsp_ready,
  output logic [7:0]              rsp_rdata,
  output logic                    ctl_wr_enable,
  output logic                    ctl_rd_enable,
  output logic [ADDR_WIDTH-1:0]   ctl_wr_addr,
  output logic [ADDR_WIDTH-1:0]   ctl_rd_addr,
  output logic [7:0]              ctl_wr_data,
  input  logic                    ctl_ack,
  input  logic                    ctl_rd_ready,
  input  logic [7:0]              ctl_rd_data,
  output logic [$clog2(DEPTH):0]  level,
  output logic                    error
);

  req_entry_t               push_entry_s;
  req_entry_t               head_s;
  logic [REQ_ENTRY_W-1:0]   head_bits_s;
  logic                     fifo_full_s;
  logic                     fifo_empty_s;
  logic                     push_s;
  logic                     pop_s;

  rq_state_e                state_r;
  logic                     cur_write_r;
  logic                     ctl_wr_enable_r;
  logic                     ctl_rd_enable_r;
  logic [ADDR_WIDTH-1:0]    ctl_wr_addr_r;
  logic [ADDR_WIDTH-1:0]    ctl_rd_addr_r;
  logic [7:0]               ctl_wr_data_r;
  logic                     rsp_valid_r;
  logic [7:0]               rsp_rdata_r;

  assign push_entry_s = {req_write, SDRAM_ADDR_W'(req_addr), req_wdata};
  assign head_s       = head_bits_s;
  assign req_ready    = !fifo_full_s;
  assign push_s       = req_valid && !fifo_full_s;

  sdram_req_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (REQ_ENTRY_W)
  ) u_fifo (
    .sd_clk (sd_clk),
    .rst_n  (rst_n),
    .push   (push_s),
    .wdata  (push_entry_s),
    .pop    (pop_s),
    .rdata  (head_bits_s),
    .level  (level),
    .full   (fifo_full_s),
    .empty  (fifo_empty_s)
  );

`ifdef SDRAM_RQ_WDOG_EN
  localparam int unsigned  WDW       = $clog2(WDOG_CYCLES) + 1;
  localparam logic [WDW-1:0] WDOG_LAST = WDW'(WDOG_CYCLES - 1);
  localparam logic [WDW-1:0] WDOG_INC  = {{(WDW-1){1'b0}}, 1'b1};

  logic [WDW-1:0] wdog_cnt_r;
  logic           error_r;
  logic           wdog_expire_s;

  assign wdog_expire_s = (state_r != S_IDLE) && (wdog_cnt_r == WDOG_LAST);
  // The head leaves the FIFO when acked, or when abandoned while still issuing.
  assign pop_s = (state_r == S_ISSUE) && (ctl_ack || wdog_expire_s);
  assign error = error_r;
`else
  assign pop_s = (state_r == S_ISSUE) && ctl_ack;
  assign error = 1'b0;
`endif

  // Request sequencer: issues the FIFO head, waits for ack and read data,
  // and owns the response register.
  always_ff @(posedge sd_clk) begin
    if (!rst_n) begin
      state_r         <= S_IDLE;
      cur_write_r     <= 1'b0;
      ctl_wr_enable_r <= 1'b0;
      ctl_rd_enable_r <= 1'b0;
      ctl_wr_addr_r   <= {ADDR_WIDTH{1'b0}};
      ctl_rd_addr_r   <= {ADDR_WIDTH{1'b0}};
      ctl_wr_data_r   <= 8'h00;
      rsp_valid_r     <= 1'b0;
      rsp_rdata_r     <= 8'h00;
`ifdef SDRAM_RQ_WDOG_EN
      wdog_cnt_r      <= {WDW{1'b0}};
      error_r         <= 1'b0;
`endif
    end else begin
      if (rsp_valid_r && rsp_ready) begin
        rsp_valid_r <= 1'b0;
      end
      case (state_r)
        S_IDLE: begin
`ifdef SDRAM_RQ_WDOG_EN
          wdog_cnt_r <= {WDW{1'b0}};
`endif
          // A read waits for the held response to be taken; a write does not.
          if (!fifo_empty_s && (head_s.write || !rsp_valid_r)) begin
            cur_write_r <= head_s.write;
            if (head_s.write) begin
              ctl_wr_enable_r <= 1'b1;
              ctl_wr_addr_r   <= ADDR_WIDTH'(head_s.addr);
              ctl_wr_data_r   <= head_s.wdata;
            end else begin
              ctl_rd_enable_r <= 1'b1;
              ctl_rd_addr_r   <= ADDR_WIDTH'(head_s.addr);
            end
            state_r <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          if (ctl_ack) begin
            ctl_wr_enable_r <= 1'b0;
            ctl_rd_enable_r <= 1'b0;
            state_r         <= cur_write_r ? S_IDLE : S_WAIT_RD;
`ifdef SDRAM_RQ_WDOG_EN
            wdog_cnt_r      <= {WDW{1'b0}};
          end else if (wdog_expire_s) begin
            ctl_wr_enable_r <= 1'b0;
            ctl_rd_enable_r <= 1'b0;
            error_r         <= 1'b1;
            state_r         <= S_IDLE;
            if (!cur_write_r) begin
              rsp_valid_r <= 1'b1;
              rsp_rdata_r <= RSP_TIMEOUT_DATA;
            end
          end else begin
            wdog_cnt_r <= wdog_cnt_r + WDOG_INC;
`endif
          end
        end
        S_WAIT_RD: begin
          if (ctl_rd_ready) begin
            rsp_valid_r <= 1'b1;
            rsp_rdata_r <= ctl_rd_data;
            state_r     <= S_IDLE;
`ifdef SDRAM_RQ_WDOG_EN
          end else if (wdog_expire_s) begin
            rsp_valid_r <= 1'b1;
            rsp_rdata_r <= RSP_TIMEOUT_DATA;
            error_r     <= 1'b1;
            state_r     <= S_IDLE;
          end else begin
            wdog_cnt_r <= wdog_cnt_r + WDOG_INC;
`endif
          end
        end
        default: begin
          state_r <= S_IDLE;
        end
      endcase
    end
  end

  assign ctl_wr_enable = ctl_wr_enable_r;
  assign ctl_rd_enable = ctl_rd_enable_r;
  assign ctl_wr_addr   = ctl_wr_addr_r;
  assign ctl_rd_addr   = ctl_rd_addr_r;
  assign ctl_wr_data   = ctl_wr_data_r;
  assign rsp_valid     = rsp_valid_r;
  assign rsp_rdata     = rsp_rdata_r;

endmodule

// File: tb/tb_sdram_request_queue.sv
// Bench for sdram_request_queue: a controller model acks requests and returns
// read data; a reference model tracks the expected issue order, occupancy and
// read responses from the host-level request stream.
`timescale 1ns/1ps
module tb_sdram_request_queue;

  localparam int AW    = 25;
  localparam int DEPTH = 8;

  logic          sd_clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          req_valid = 1'b0;
  logic          req_ready;
  logic          req_write = 1'b0;
  logic [AW-1:0] req_addr = '0;
  logic [7:0]    req_wdata = 8'h00;
  logic          rsp_valid;
  logic          rsp_ready = 1'b1;
  logic [7:0]    rsp_rdata;
  logic          ctl_wr_enable, ctl_rd_enable;
  logic [AW-1:0] ctl_wr_addr, ctl_rd_addr;
  logic [7:0]    ctl_wr_data;
  logic          ctl_ack = 1'b0;
  logic          ctl_rd_ready = 1'b0;
  logic [7:0]    ctl_rd_data = 8'h00;
  logic [3:0]    level;
  logic          error;

  always #5 sd_clk = ~sd_clk;

  sdram_request_queue #(.ADDR_WIDTH(AW), .DEPTH(DEPTH), .WDOG_CYCLES(64)) dut (
    .sd_clk(sd_clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
    .ctl_wr_enable(ctl_wr_enable), .ctl_rd_enable(ctl_rd_enable),
    .ctl_wr_addr(ctl_wr_addr), .ctl_rd_addr(ctl_rd_addr), .ctl_wr_data(ctl_wr_data),
    .ctl_ack(ctl_ack), .ctl_rd_ready(ctl_rd_ready), .ctl_rd_data(ctl_rd_data),
    .level(level), .error(error)
  );

  int unsigned n_vec = 0;
  int unsigned n_err = 0;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [7:0] dflt(input logic [AW-1:0] a);
    return a[7:0] ^ 8'h3C;
  endfunction

  // ---------------- controller model ----------------
  int   ack_delay = 0, rd_delay = 0, ack_cnt = 0, rd_cnt = 0;
  bit   ack_en = 1'b1, rd_pend = 1'b0, noise = 1'b0;
  logic [7:0] rd_val;
  logic [7:0] ctl_mem [int];

  always @(posedge sd_clk) begin
    #1;
    ctl_rd_ready = 1'b0;
    ctl_rd_data  = 8'($urandom);
    if (!rst_n) begin
      ctl_ack = 1'b0; ack_cnt = 0; rd_pend = 1'b0; ctl_mem.delete();
    end else begin
      if (rd_pend) begin
        if (rd_cnt >= rd_delay) begin
          ctl_rd_ready = 1'b1; ctl_rd_data = rd_val; rd_pend = 1'b0;
        end else rd_cnt++;
      end else if (noise && ($urandom_range(0, 3) == 0)) begin
        ctl_rd_ready = 1'b1;   // stray strobe the queue must ignore
      end
      if (ctl_ack) ctl_ack = 1'b0;
      else if (ctl_wr_enable || ctl_rd_enable) begin
        if (ack_en && ack_cnt >= ack_delay) begin
          ctl_ack = 1'b1; ack_cnt = 0;
          if (ctl_wr_enable) ctl_mem[int'(ctl_wr_addr)] = ctl_wr_data;
          else begin
            rd_pend = 1'b1; rd_cnt = 0;
            rd_val = ctl_mem.exists(int'(ctl_rd_addr)) ? ctl_mem[int'(ctl_rd_addr)] : dflt(ctl_rd_addr);
          end
        end else ack_cnt++;
      end
    end
  end

  // ---------------- reference model / monitor ----------------
  typedef struct { bit wr; logic [AW-1:0] addr; logic [7:0] data; } op_t;
  op_t        exp_q[$];
  logic [7:0] exp_rsp_q[$];
  logic [7:0] ref_mem [int];
  op_t        op;
  int  level_exp = 0;
  int  wr_eps = 0, rd_eps = 0, rsp_cnt = 0;
  logic [7:0] last_rsp = 8'h00;
  bit  prev_wr = 1'b0, prev_rd = 1'b0, mon_on = 1'b1;

  always @(negedge sd_clk) begin
    if (mon_on) begin
      check_val("level", level, level_exp);
      check_val("req_ready", req_ready, (level_exp != DEPTH));
      if (ctl_wr_enable && ctl_rd_enable) check_val("one_enable", 1, 0);
      if ((ctl_wr_enable && !prev_wr) || (ctl_rd_enable && !prev_rd)) begin
        if (ctl_wr_enable) wr_eps++; else rd_eps++;
        if (exp_q.size() == 0) check_val("spurious_issue", 1, 0);
        else begin
          op = exp_q.pop_front();
          check_val("issue_write", ctl_wr_enable, op.wr);
          if (op.wr) begin
            check_val("wr_addr", ctl_wr_addr, op.addr);
            check_val("wr_data", ctl_wr_data, op.data);
          end else begin
            check_val("rd_addr", ctl_rd_addr, op.addr);
            check_val("rd_gate", rsp_valid, 0);
          end
        end
      end
      if (rsp_valid && rsp_ready) begin
        rsp_cnt++; last_rsp = rsp_rdata;
        if (exp_rsp_q.size() == 0) check_val("spurious_rsp", 1, 0);
        else check_val("rsp_data", rsp_rdata, exp_rsp_q.pop_front());
      end
      // effect of the coming edge
      if (!rst_n) begin
        level_exp = 0; exp_q.delete(); exp_rsp_q.delete(); ref_mem.delete();
      end else begin
        if (req_valid && level_exp != DEPTH) begin
          op.wr = req_write; op.addr = req_addr; op.data = req_wdata;
          exp_q.push_back(op);
          if (req_write) ref_mem[int'(req_addr)] = req_wdata;
          else exp_rsp_q.push_back(ref_mem.exists(int'(req_addr)) ? ref_mem[int'(req_addr)] : dflt(req_addr));
          level_exp++;
        end
        if ((ctl_wr_enable || ctl_rd_enable) && ctl_ack) level_exp--;
      end
    end
    prev_wr = ctl_wr_enable;
    prev_rd = ctl_rd_enable;
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick(input int n);
    repeat (n) @(posedge sd_clk);
    #2;
  endtask

  task automatic push(input bit w, input logic [AW-1:0] a, input logic [7:0] d);
    int t;
    t = 0;
    req_valid = 1'b1; req_write = w; req_addr = a; req_wdata = d;
    @(negedge sd_clk);
    while (!req_ready && t < 300) begin t++; @(negedge sd_clk); end
    if (t >= 300) check_val("push_timeout", 1, 0);
    @(posedge sd_clk); #2;
    req_valid = 1'b0;
  endtask

  task automatic drain();
    int t;
    t = 0;
    req_valid = 1'b0; rsp_ready = 1'b1; ack_en = 1'b1; ack_delay = 0; noise = 1'b0;
    while ((exp_q.size() != 0 || exp_rsp_q.size() != 0 || level_exp != 0 || rd_pend) && t < 500) begin
      t++; tick(1);
    end
    tick(2);
    check_val("drain_done", (t < 500), 1);
    check_val("drain_exp_q", exp_q.size(), 0);
    check_val("drain_rsp_q", exp_rsp_q.size(), 0);
  endtask

  initial begin
    #1ms;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int w0, r0, s0;
    tick(3);
    rst_n = 1'b1;
    @(negedge sd_clk);
    check_val("rst_rsp_valid", rsp_valid, 0);
    check_val("rst_rsp_rdata", rsp_rdata, 0);
    check_val("rst_wr_en", ctl_wr_enable, 0);
    check_val("rst_rd_en", ctl_rd_enable, 0);
    check_val("rst_wr_addr", ctl_wr_addr, 0);
    check_val("rst_rd_addr", ctl_rd_addr, 0);
    check_val("rst_wr_data", ctl_wr_data, 0);
    check_val("rst_error", error, 0);
    tick(1);

    // write then read the same address
    ack_delay = 1; rd_delay = 2;
    w0 = wr_eps; r0 = rd_eps; s0 = rsp_cnt;
    push(1'b1, 25'h0000123, 8'hA5);
    push(1'b0, 25'h0000123, 8'h00);
    drain();
    check_val("wr_rd_wr_eps", wr_eps - w0, 1);
    check_val("wr_rd_rd_eps", rd_eps - r0, 1);
    check_val("wr_rd_rsp_cnt", rsp_cnt - s0, 1);
    check_val("wr_rd_rdata", last_rsp, 8'hA5);

    // fill with slow acks
    ack_delay = 30; w0 = wr_eps;
    for (int i = 0; i < 8; i++) push(1'b1, 25'h40 + 25'(i), 8'(i * 17));
    @(negedge sd_clk);
    check_val("full_level", level, 8);
    check_val("full_ready", req_ready, 0);
    tick(1);
    push(1'b1, 25'h48, 8'h99);
    drain();
    check_val("full_wr_eps", wr_eps - w0, 9);

    // second read withheld while response held
    rsp_ready = 1'b0; ack_delay = 0; rd_delay = 1; r0 = rd_eps;
    push(1'b0, 25'h5, 8'h00);
    push(1'b0, 25'h6, 8'h00);
    tick(20);
    check_val("rd_withheld", rd_eps - r0, 1);
    check_val("rd_held_valid", rsp_valid, 1);
    drain();
    check_val("rd_both_issued", rd_eps - r0, 2);

    // simultaneous push and pop at level 3
    ack_en = 1'b0;
    for (int i = 0; i < 3; i++) push(1'b1, 25'h60 + 25'(i), 8'(8'hC0 + i));
    @(negedge sd_clk);
    check_val("pp_level_before", level, 3);
    tick(1);
    ack_en = 1'b1; ack_delay = 0;
    tick(1);
    req_valid = 1'b1; req_write = 1'b1; req_addr = 25'h63; req_wdata = 8'hC3;
    tick(1);
    req_valid = 1'b0;
    @(negedge sd_clk);
    check_val("pp_level_after", level, 3);
    drain();

    // reset while waiting for read data with 4 queued entries
    ack_delay = 0; rd_delay = 60;
    push(1'b0, 25'h7, 8'h00);
    for (int i = 0; i < 4; i++) push(1'b1, 25'h70 + 25'(i), 8'(i));
    tick(3);
    check_val("rst_mid_level_before", level, 4);
    rst_n = 1'b0;
    tick(1);
    rst_n = 1'b1;
    @(negedge sd_clk);
    check_val("rst_mid_level", level, 0);
    check_val("rst_mid_wr_en", ctl_wr_enable, 0);
    check_val("rst_mid_rd_en", ctl_rd_enable, 0);
    check_val("rst_mid_rsp_valid", rsp_valid, 0);
    tick(1);
    rd_delay = 0;

    // randomized traffic
    noise = 1'b1;
    for (int c = 0; c < 1500; c++) begin
      req_valid = ($urandom_range(0, 9) < 6);
      req_write = $urandom_range(0, 1);
      req_addr  = 25'($urandom_range(0, 15));
      req_wdata = 8'($urandom);
      rsp_ready = ($urandom_range(0, 9) < 7);
      ack_delay = $urandom_range(0, 3);
      rd_delay  = $urandom_range(0, 3);
      tick(1);
    end
    drain();

`ifdef SDRAM_RQ_WDOG_EN
    // stuck controller: read abandoned by the watchdog
    mon_on = 1'b0; rst_n = 1'b0; tick(1); rst_n = 1'b1;
    ack_en = 1'b0; rsp_ready = 1'b0;
    push(1'b0, 25'h9, 8'h00);
    tick(80);
    @(negedge sd_clk);
    check_val("wdog_error", error, 1);
    check_val("wdog_rd_en", ctl_rd_enable, 0);
    check_val("wdog_rsp_valid", rsp_valid, 1);
    check_val("wdog_rsp_rdata", rsp_rdata, 8'hFF);
    check_val("wdog_level", level, 0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/sdram_request_queue.md
# sdram_request_queue

Host-side request buffer sitting directly upstream of the SDRAM controller. Accepts byte-wide read/write requests over a valid/ready interface and buffers them in a small FIFO. Presents them one at a time to the controller's enable/ack port and returns read data through a single-entry valid/ready response register. Requests complete strictly in order, with at most one read outstanding.

## Interface
- ADDR_WIDTH, 25, host byte address width (bank+row+col)
- DEPTH, 8, request FIFO entries; power of two, ≥2
- WDOG_CYCLES, 64, watchdog limit in cycles (only with SDRAM_RQ_WDOG_EN)

Ports:
- sd_clk  in  1  clock
- rst_n  in  1  reset, synchronous, active-low; clock sd_clk
- req_valid  in  1  request present
- req_ready  out  1  FIFO can accept
- req_write  in  1  1=write, 0=read
- req_addr  in  ADDR_WIDTH  byte address
- req_wdata  in  8  write data
- rsp_valid  out  1  read data held
- rsp_ready  in  1  host takes response
- rsp_rdata  out  8  read data
- ctl_wr_enable, ctl_rd_enable  out  1 each  controller request strobes
- ctl_wr_addr, ctl_rd_addr  out  ADDR_WIDTH  controller addresses
- ctl_wr_data  out  8  controller write data
- ctl_ack  in  1  controller accepted request
- ctl_rd_ready  in  1  controller read data valid this cycle
- ctl_rd_data  in  8  controller read data
- level  out  $clog2(DEPTH)+1  FIFO occupancy
- error  out  1  sticky watchdog flag

## Operation
- FIFO entry {write, addr, wdata}; push on req_valid&&req_ready; req_ready = level != DEPTH (no bypass when full).
- FSM states:
  - S_IDLE: if FIFO non-empty and (head is write, or rsp_valid==0), load ctl_* from head and assert exactly one enable -> S_ISSUE.
  - S_ISSUE: hold enable/addr/data until ctl_ack. On ack: deassert enable, pop head. Write -> S_IDLE; read -> S_WAIT_RD.
  - S_WAIT_RD: on ctl_rd_ready, rsp_rdata<=ctl_rd_data, rsp_valid<=1 -> S_IDLE.
- rsp_valid clears on rsp_valid&&rsp_ready. A new read is not issued while rsp_valid=1; writes still issue.
- Write addr/data is driven only on ctl_wr_*; ctl_rd_* is driven only for reads. Unused outputs hold their last value.
- ctl_rd_ready outside S_WAIT_RD is ignored.

## Timing
- Reset: req_ready=1 (derived), rsp_valid=0, rsp_rdata=0, ctl_*_enable=0, ctl addr/data=0, level=0, error=0, FSM=S_IDLE, FIFO emptied. Reset mid-transaction drops all entries and any pending response.
- Push at edge N; level increments at N; head is issuable in S_IDLE at N+1; enable is visible from N+2.
- Enable drops the cycle after ctl_ack is sampled. Pop and level decrement happen in the same edge.
- Simultaneous push and pop: level unchanged; wrap-around uses pointers with an extra MSB.
- Read latency: host response appears 1 cycle after ctl_rd_ready.
- Empty FIFO in S_IDLE: enables stay 0.

## Configuration
- SDRAM_RQ_WDOG_EN defined:
  - Counter runs in S_ISSUE and S_WAIT_RD and resets on each state entry.
  - When it reaches WDOG_CYCLES-1: deassert enable and pop the head if still in S_ISSUE, set error=1 (sticky until reset), and go to S_IDLE.
  - A read timing out produces a response with rsp_rdata=8'hFF.
- Undefined: no counter; the FSM waits indefinitely; error tied 0.

## Structure
- Shared package sdram_pkg: FSM state enum, request-entry struct typedef, RSP_TIMEOUT_DATA=8'hFF.
- One sub-module: sdram_req_fifo (parameterised sync FIFO with push/pop/level); FSM and response register live in the top.

## Test plan
- Write 0x0000123 data 0xA5, then read 0x0000123 (controller model returns 0xA5 3 cycles after ack) -> exactly one wr_enable and one rd_enable episode; rsp_rdata=0xA5 with rsp_valid set once.
- Push 8 writes with the controller acking slowly -> level=8, req_ready=0 on the 9th; items are drained in order with no duplicated enables.
- Two reads with rsp_ready=0 -> second rd_enable is withheld until the first response is taken.
- Simultaneous push/pop at level 3 -> level stays 3; pointer wrap after 20 pushes keeps data in order.
- rst_n low while in S_WAIT_RD with 4 queued entries -> next cycle: level=0, enables 0, rsp_valid=0.
- With SDRAM_RQ_WDOG_EN and ctl_ack stuck at 0 -> after 64 cycles the enable drops, error=1, and a read returns 0xFF.
